// File: rtl/i2s_pkg.sv
// Shared I2S definitions for the transmit and receive paths.
package i2s_pkg;
  typedef logic signed [15:0] sample_t;
  localparam int I2S_SLOT_WIDTH  = 32;
  localparam int I2S_FRAME_BCLKS = 64;
endpackage

// File: rtl/i2s_bclk_gen.sv
// BCLK/LRCLK generator: audio_clk divider plus the per-frame bit counter.
// bit_cnt is the count that takes effect on the current fall event.
module i2s_bclk_gen
  import i2s_pkg::*;
#(
  parameter int CLK_DIV    = 16,
  parameter int SLOT_WIDTH = I2S_SLOT_WIDTH,
  localparam int DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1,
  localparam int BIT_W     = $clog2(2 * SLOT_WIDTH)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  output logic             bclk,
  output logic             lrclk,
  output logic             fall_event,
  output logic             frame_load,
  output logic [BIT_W-1:0] bit_cnt
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_WIDTH - 1);
  localparam logic [BIT_W-1:0] SLOT_W   = BIT_W'(SLOT_WIDTH);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             bclk_q, bclk_d;
  logic             lrclk_q, lrclk_d;
  logic             toggle;

  always_comb begin
    toggle     = (div_cnt_q == DIV_LAST);
    div_cnt_d  = toggle ? '0 : div_cnt_q + DIV_W'(1);
    bclk_d     = toggle ? ~bclk_q : bclk_q;
    fall_event = toggle && bclk_q;
    bit_cnt    = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + BIT_W'(1);
    bit_cnt_d  = fall_event ? bit_cnt : bit_cnt_q;
    lrclk_d    = fall_event ? (bit_cnt >= SLOT_W) : lrclk_q;
    frame_load = fall_event && (bit_cnt == '0);
  end

  // Counter parks on the last bit so the very first fall event is a frame load.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      div_cnt_q <= '0;
      bit_cnt_q <= BIT_LAST;
      bclk_q    <= 1'b0;
      lrclk_q   <= 1'b1;
    end else begin
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      bclk_q    <= bclk_d;
      lrclk_q   <= lrclk_d;
    end
  end

  assign bclk  = bclk_q;
  assign lrclk = lrclk_q;

endmodule

// File: rtl/i2s_tx.sv
// I2S master transmitter: one-deep sample holding buffer, per-channel shift
// registers and underrun accounting on top of the BCLK/LRCLK generator.
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int CLK_DIV      = 16,
  parameter int SAMPLE_WIDTH = 16,
  parameter int SLOT_WIDTH   = I2S_SLOT_WIDTH
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           sample_valid_in,
  output logic                           sample_ready_out,
  input  logic signed [SAMPLE_WIDTH-1:0] left_in,
  input  logic signed [SAMPLE_WIDTH-1:0] right_in,
  output logic                           bclk_out,
  output logic                           lrclk_out,
  output logic                           sdata_out,
  output logic                           frame_start_out,
  output logic                           underrun_out,
  output logic [15:0]                    underrun_count_out
);

  localparam int BIT_W = $clog2(2 * SLOT_WIDTH);
  localparam logic [BIT_W-1:0] L_FIRST = BIT_W'(1);
  localparam logic [BIT_W-1:0] L_LAST  = BIT_W'(SAMPLE_WIDTH);
  localparam logic [BIT_W-1:0] R_FIRST = BIT_W'(SLOT_WIDTH + 1);
  localparam logic [BIT_W-1:0] R_LAST  = BIT_W'(SLOT_WIDTH + SAMPLE_WIDTH);

  logic             fall_event, frame_load;
  logic [BIT_W-1:0] bit_cnt;

  logic                    buf_full_q, buf_full_d;
  logic [SAMPLE_WIDTH-1:0] buf_l_q, buf_l_d, buf_r_q, buf_r_d;
  logic [SAMPLE_WIDTH-1:0] shift_l_q, shift_l_d, shift_r_q, shift_r_d;
  logic                    sdata_q, sdata_d;
  logic                    frame_start_q, frame_start_d;
  logic                    underrun_q, underrun_d;
  logic [15:0]             ucount_q, ucount_d;
  logic                    accept;

  i2s_bclk_gen #(
    .CLK_DIV    (CLK_DIV),
    .SLOT_WIDTH (SLOT_WIDTH)
  ) u_bclk_gen (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .bclk       (bclk_out),
    .lrclk      (lrclk_out),
    .fall_event (fall_event),
    .frame_load (frame_load),
    .bit_cnt    (bit_cnt)
  );

  assign accept = sample_valid_in && !buf_full_q;

  always_comb begin
    buf_full_d    = buf_full_q;
    buf_l_d       = buf_l_q;
    buf_r_d       = buf_r_q;
    shift_l_d     = shift_l_q;
    shift_r_d     = shift_r_q;
    sdata_d       = sdata_q;
    frame_start_d = 1'b0;
    underrun_d    = 1'b0;
    ucount_d      = ucount_q;

    if (accept) begin
      buf_full_d = 1'b1;
      buf_l_d    = left_in;
      buf_r_d    = right_in;
    end

    // A load only sees the buffer as it stood before this edge, so an
    // accept coinciding with a load waits for the following frame.
    if (fall_event) begin
      sdata_d = 1'b0;
      if (frame_load) begin
        frame_start_d = 1'b1;
        if (buf_full_q) begin
          shift_l_d  = buf_l_q;
          shift_r_d  = buf_r_q;
          buf_full_d = 1'b0;
        end else begin
          shift_l_d  = '0;
          shift_r_d  = '0;
          underrun_d = 1'b1;
          if (ucount_q != 16'hFFFF) ucount_d = ucount_q + 16'd1;
        end
      end else if (bit_cnt >= L_FIRST && bit_cnt <= L_LAST) begin
        sdata_d   = shift_l_q[SAMPLE_WIDTH-1];
        shift_l_d = {shift_l_q[SAMPLE_WIDTH-2:0], 1'b0};
      end else if (bit_cnt >= R_FIRST && bit_cnt <= R_LAST) begin
        sdata_d   = shift_r_q[SAMPLE_WIDTH-1];
        shift_r_d = {shift_r_q[SAMPLE_WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      buf_full_q    <= 1'b0;
      buf_l_q       <= '0;
      buf_r_q       <= '0;
      shift_l_q     <= '0;
      shift_r_q     <= '0;
      sdata_q       <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      ucount_q      <= '0;
    end else begin
      buf_full_q    <= buf_full_d;
      buf_l_q       <= buf_l_d;
      buf_r_q       <= buf_r_d;
      shift_l_q     <= shift_l_d;
      shift_r_q     <= shift_r_d;
      sdata_q       <= sdata_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
      ucount_q      <= ucount_d;
    end
  end

  assign sample_ready_out   = !buf_full_q;
  assign sdata_out          = sdata_q;
  assign frame_start_out    = frame_start_q;
  assign underrun_out       = underrun_q;
  assign underrun_count_out = ucount_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Scoreboard bench for i2s_tx: accepted samples are queued with their accept
// cycle; a monitor decodes each frame off BCLK rising edges and checks it.
`timescale 1ns/1ps
module tb_i2s_tx;
  import i2s_pkg::*;

  localparam int FRAME_CYC  = 2048;
  localparam int FIRST_LOAD = 32;
  localparam int WAIT_MAX   = 5000;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        sample_valid_in = 1'b0;
  logic        sample_ready_out;
  sample_t     left_in = '0;
  sample_t     right_in = '0;
  logic        bclk_out, lrclk_out, sdata_out;
  logic        frame_start_out, underrun_out;
  logic [15:0] underrun_count_out;

  always #5 clk_in = ~clk_in;

  i2s_tx dut (
    .clk_in             (clk_in),
    .rst_in             (rst_in),
    .sample_valid_in    (sample_valid_in),
    .sample_ready_out   (sample_ready_out),
    .left_in            (left_in),
    .right_in           (right_in),
    .bclk_out           (bclk_out),
    .lrclk_out          (lrclk_out),
    .sdata_out          (sdata_out),
    .frame_start_out    (frame_start_out),
    .underrun_out       (underrun_out),
    .underrun_count_out (underrun_count_out)
  );

  typedef struct {
    int          acc_cyc;
    logic [15:0] l;
    logic [15:0] r;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc;

  always @(posedge clk_in or negedge rst_in)
    if (!rst_in) cyc <= 0;
    else         cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Monitor / scoreboard
  logic        prev_bclk = 1'b0;
  logic        in_frame  = 1'b0;
  int          idx       = 0;
  int          last_load = -1;
  int          ucnt_m    = 0;
  logic        exp_under;
  exp_t        ent;
  logic [63:0] got_sd, got_lr;
  logic [15:0] cur_l, cur_r, wl, wr;
  logic        pad;
  int          lr_bad;

  always @(negedge clk_in) begin
    if (!rst_in) begin
      sb_q.delete();
      in_frame  = 1'b0;
      idx       = 0;
      last_load = -1;
      ucnt_m    = 0;
      prev_bclk = 1'b0;
    end else begin
      if (frame_start_out) begin
        if (last_load < 0) chk("first_load_cycle", cyc, FIRST_LOAD);
        else               chk("frame_period", cyc - last_load, FRAME_CYC);
        last_load = cyc;
        exp_under = 1'b1;
        if (sb_q.size() > 0)
          if (sb_q[0].acc_cyc < cyc) exp_under = 1'b0;
        if (exp_under) begin
          cur_l = '0;
          cur_r = '0;
          if (ucnt_m < 65535) ucnt_m++;
        end else begin
          ent   = sb_q.pop_front();
          cur_l = ent.l;
          cur_r = ent.r;
        end
        chk("underrun_pulse", underrun_out, exp_under);
        chk("underrun_count", underrun_count_out, ucnt_m[15:0]);
        in_frame = 1'b1;
        idx      = 0;
        got_sd   = '0;
        got_lr   = '0;
      end else if (in_frame && bclk_out && !prev_bclk) begin
        got_sd[idx] = sdata_out;
        got_lr[idx] = lrclk_out;
        idx++;
        if (idx == I2S_FRAME_BCLKS) begin
          wl = '0; wr = '0; pad = 1'b0; lr_bad = 0;
          for (int b = 1; b <= 16; b++) begin
            wl = {wl[14:0], got_sd[b]};
            wr = {wr[14:0], got_sd[32+b]};
          end
          for (int i = 0; i < 64; i++) begin
            if (!((i >= 1 && i <= 16) || (i >= 33 && i <= 48))) pad = pad | got_sd[i];
            if (got_lr[i] !== (i >= 32)) lr_bad++;
          end
          chk("left_word", wl, cur_l);
          chk("right_word", wr, cur_r);
          chk("pad_bits_zero", pad, 1'b0);
          chk("lrclk_pattern_errors", lr_bad, 0);
          in_frame = 1'b0;
        end
      end
      prev_bclk = bclk_out;
    end
  end

  task automatic wait_load(input string name);
    int n = 0;
    do begin
      @(negedge clk_in);
      n++;
    end while (!frame_start_out && n < WAIT_MAX);
    chk({name, "_seen"}, frame_start_out, 1'b1);
  endtask

  task automatic offer(input logic [15:0] l, input logic [15:0] r, input bit keep, output int acc);
    int   n = 0;
    exp_t e;
    @(negedge clk_in);
    sample_valid_in = 1'b1;
    left_in  = l;
    right_in = r;
    while (!sample_ready_out && n < WAIT_MAX) begin
      @(negedge clk_in);
      n++;
    end
    chk("ready_before_accept", sample_ready_out, 1'b1);
    acc       = cyc + 1;
    e.acc_cyc = acc;
    e.l       = l;
    e.r       = r;
    if (sample_ready_out) sb_q.push_back(e);
    @(posedge clk_in);
    #1;
    chk("ready_low_after_accept", sample_ready_out, 1'b0);
    if (!keep) sample_valid_in = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_bclk"},        bclk_out, 1'b0);
    chk({tag, "_lrclk"},       lrclk_out, 1'b1);
    chk({tag, "_sdata"},       sdata_out, 1'b0);
    chk({tag, "_ready"},       sample_ready_out, 1'b1);
    chk({tag, "_frame_start"}, frame_start_out, 1'b0);
    chk({tag, "_underrun"},    underrun_out, 1'b0);
    chk({tag, "_count"},       underrun_count_out, 16'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clk_in);
    #2 rst_in = 1'b0;
    sample_valid_in = 1'b0;
    repeat (3) @(negedge clk_in);
    #2 rst_in = 1'b1;
  endtask

  initial begin
    int acc, prev_acc, tgt, e0, n;

    #1 rst_in = 1'b0;
    #20;
    check_reset_values("por");
    @(negedge clk_in);
    #2 rst_in = 1'b1;

    // Idle: every frame underruns with silent data.
    repeat (10) wait_load("idle_frame");
    chk("idle_count_after_10", underrun_count_out, 16'd10);

    // Sample accepted before the first load plays in frame one.
    pulse_reset();
    offer(16'hA5C3, 16'h5A3C, 1'b0, acc);
    repeat (2) wait_load("directed_frame");

    // Streaming with valid held high: one accept per frame.
    prev_acc = 0;
    for (int i = 0; i < 5; i++) begin
      offer(16'h1000 + 16'(i), 16'h2000 + 16'(i), 1'b1, acc);
      if (i >= 2) chk("stream_accept_spacing", acc - prev_acc, FRAME_CYC);
      prev_acc = acc;
    end
    sample_valid_in = 1'b0;

    // Accept landing exactly on a load edge: that frame underruns.
    wait_load("stream_last_frame");
    tgt = cyc + FRAME_CYC;
    n = 0;
    while (cyc < tgt - 2 && n < WAIT_MAX) begin
      @(negedge clk_in);
      n++;
    end
    chk("reach_load_minus_2", cyc, tgt - 2);
    offer(16'h7FFF, 16'h8001, 1'b0, acc);
    chk("late_accept_on_load_edge", acc, tgt);
    repeat (3) wait_load("late_frame");

    // Reset mid-frame with the buffer full.
    e0 = cyc;
    offer(16'h1234, 16'h4321, 1'b0, acc);
    n = 0;
    while (cyc < e0 + 20 * 32 + 5 && n < WAIT_MAX) begin
      @(negedge clk_in);
      n++;
    end
    chk("buffer_full_before_reset", sample_ready_out, 1'b0);
    #2 rst_in = 1'b0;
    #1;
    check_reset_values("midframe_rst");
    repeat (3) @(negedge clk_in);
    #2 rst_in = 1'b1;
    #1;
    chk("count_after_release", underrun_count_out, 16'd0);
    chk("ready_after_release", sample_ready_out, 1'b1);
    repeat (2) wait_load("post_reset_frame");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #900000;
    n_err++;
    $display("FAIL watchdog: run still active at %0t, want completion", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
- I2S master transmitter that drives a stereo DAC or amplifier. It is the output-side counterpart of the mic receivers, which clock data in on pmoda and pmodb.
- Takes 16-bit signed left/right sample pairs over a valid/ready handshake.
- Serialises them in standard Philips I2S framing, 64 BCLK per frame, with a one-BCLK data delay.
- Generates BCLK and LRCLK from audio_clk (98.304 MHz). With defaults this gives BCLK 3.072 MHz and LRCLK 48 kHz, aligned to the 2048-cycle audio_trigger period.

Parameters:
- CLK_DIV, 16: audio_clk cycles per BCLK half-period; must be ≥2.
- SAMPLE_WIDTH, 16: sample bits per channel.
- SLOT_WIDTH, 32: BCLKs per channel slot; must be ≥ SAMPLE_WIDTH+1.

Ports:
- clk_in  input  1  audio_clk domain clock.
- rst_in  input  1  asynchronous, active-low reset.
- sample_valid_in  input  1  sample pair offered.
- sample_ready_out  output  1  holding buffer empty; may accept.
- left_in  input  SAMPLE_WIDTH  signed left sample.
- right_in  input  SAMPLE_WIDTH  signed right sample.
- bclk_out  output  1  I2S bit clock.
- lrclk_out  output  1  word select; 0 = left, 1 = right.
- sdata_out  output  1  serial data, MSB first.
- frame_start_out  output  1  one-cycle pulse at each frame load.
- underrun_out  output  1  one-cycle pulse when a frame loads with no sample.
- underrun_count_out  output  16  saturating underrun count.

Behaviour:
- Reset values (rst_in low, async): bclk_out=0, lrclk_out=1, sdata_out=0, sample_ready_out=1, frame_start_out=0, underrun_out=0, underrun_count_out=0. Also div_cnt=0, bit_cnt=2*SLOT_WIDTH-1, holding buffer empty, shift registers zero.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps; bclk_out toggles on the cycle div_cnt==CLK_DIV-1.
  - A "fall event" is the cycle bclk_out goes 1→0. All state changes on the serial side happen only on fall events.
- Bit counter: bit_cnt increments mod 2*SLOT_WIDTH on each fall event.
- Per fall event, driven from the new bit_cnt:
  - lrclk_out = (bit_cnt ≥ SLOT_WIDTH).
  - sdata_out = left bit (SAMPLE_WIDTH-bit_cnt) for bit_cnt in 1..SAMPLE_WIDTH.
  - sdata_out = right bit (SAMPLE_WIDTH-(bit_cnt-SLOT_WIDTH)) for bit_cnt in SLOT_WIDTH+1..SLOT_WIDTH+SAMPLE_WIDTH.
  - sdata_out = 0 otherwise.
- Frame load (fall event where bit_cnt wraps to 0):
  - frame_start_out pulses.
  - If the holding buffer is full: copy it to the shift registers and mark it empty.
  - Else: load zeros, pulse underrun_out, and increment underrun_count_out, saturating at 16'hFFFF.
- First fall event after reset is at cycle 2*CLK_DIV (cycle 32 with defaults). It is a frame load, so the first frame is an underrun unless a sample was accepted earlier. Frame period is 2*CLK_DIV*2*SLOT_WIDTH cycles (2048 with defaults).
- Handshake:
  - Accept on cycle sample_valid_in && sample_ready_out; latch left_in/right_in; sample_ready_out=0 from the next cycle.
  - sample_ready_out returns to 1 the cycle after the frame load that consumes the buffer.
  - No bypass: an accept on the same cycle as a load (buffer empty) still underruns that frame, and the sample plays in the following frame.
  - Inputs while not ready are ignored; no overwrite.
- Reset mid-frame: all state returns to reset values immediately. Any buffered sample is discarded. No partial-frame completion.
- sdata_out and lrclk_out change only coincident with BCLK falling, so they are stable across every BCLK rising edge.

Decomposition:
- Package i2s_pkg:
  - typedef sample_t = logic signed [15:0].
  - localparams I2S_SLOT_WIDTH=32 and I2S_FRAME_BCLKS=64.
  - Shared with the receive side.
- Sub-module i2s_bclk_gen:
  - Contains the divider plus bit counter.
  - Outputs bclk, lrclk, fall_event, bit_cnt and frame_load.
  - i2s_tx adds the holding buffer, shift registers and underrun logic.

Test Plan:
- Reset → all outputs at the reset values listed in Behaviour.
- Release reset, no input → first frame_start_out at cycle 32, underrun_out pulses, count=1. After 10 frames, count=10 and sdata_out is constantly 0.
- Accept left=16'hA5C3, right=16'h5A3C before the first load:
  - Sampled on BCLK rising edges, slot bits 1..16 read 1010010111000011 with lrclk=0.
  - Bits 33..48 read 0101101000111100 with lrclk=1.
  - All other bits are 0.
- Hold sample_valid_in high with an incrementing pattern:
  - ready pulses once per 2048 cycles.
  - Exactly one sample per frame, no underruns, no duplicates.
  - Frame period is exactly 2048 cycles.
- Offer a sample on the exact frame-load cycle with the buffer empty → that frame underruns (zeros) and the sample appears in the next frame.
- Assert reset at bit_cnt=20 with the buffer full → outputs take reset values asynchronously, buffer is empty, and the count is 0 after release.
